// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared size encodings, LSU state type and memory geometry
package mips_mem_pkg;

    localparam int ADDR_WORD_BITS_DEFAULT = 8;

    // Size encodings double as the memory store_control encoding.
    localparam logic [1:0] SIZE_WORD    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_BYTE    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/mips_lane_align.sv
// rtl/mips_lane_align.sv - big-endian lane extract/extend and lane merge
module mips_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [4:0]  byte_shift;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Offset 0 is the most significant byte, so the shift is (3 - offset) * 8.
    assign byte_shift = {~offset, 3'b000};
    assign byte_lane  = 8'(word_in >> byte_shift);
    assign half_lane  = offset[1] ? word_in[15:0] : word_in[31:16];

    always_comb begin
        load_data   = word_in;
        merged_word = wdata;
        case (size)
            SIZE_BYTE: begin
                load_data   = is_unsigned ? {24'b0, byte_lane}
                                          : {{24{byte_lane[7]}}, byte_lane};
                merged_word = (word_in & ~(32'h0000_00ff << byte_shift))
                            | (32'(wdata[7:0]) << byte_shift);
            end
            SIZE_HALF: begin
                load_data   = is_unsigned ? {16'b0, half_lane}
                                          : {{16{half_lane[15]}}, half_lane};
                merged_word = offset[1] ? {word_in[31:16], wdata[15:0]}
                                        : {wdata[15:0], word_in[15:0]};
            end
            default: begin
                load_data   = word_in;
                merged_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mips_load_store_unit.sv
// rtl/mips_load_store_unit.sv - load/store request sequencer driving the word-indexed data memory
module mips_load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WORD_BITS = ADDR_WORD_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_store_control,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    lsu_state_t  state;
    logic        r_store;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_offset;
    logic [31:0] r_wdata;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign req_err = (req_size == SIZE_ILLEGAL)
                  || (req_size == SIZE_HALF && req_addr[0])
                  || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
                  || (req_addr[31:ADDR_WORD_BITS+2] != '0);

    mips_lane_align u_lane_align (
        .word_in     (mem_read_data),
        .offset      (r_offset),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .wdata       (r_wdata),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            req_ready         <= 1'b1;
            resp_valid        <= 1'b0;
            resp_data         <= '0;
            resp_err          <= 1'b0;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            mem_address       <= '0;
            mem_write_data    <= '0;
            mem_store_control <= SIZE_WORD;
            r_store           <= 1'b0;
            r_size            <= SIZE_WORD;
            r_unsigned        <= 1'b0;
            r_offset          <= 2'b00;
            r_wdata           <= '0;
        end else begin
            mem_store_control <= SIZE_WORD;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        r_store    <= req_store;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_offset   <= req_addr[1:0];
                        r_wdata    <= req_wdata;
                        if (req_err) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                        end else begin
                            mem_address <= 32'(req_addr[ADDR_WORD_BITS+1:2]);
                            if (req_store && req_size == SIZE_WORD) begin
                                state          <= ST_WRITE;
                                mem_write      <= 1'b1;
                                mem_write_data <= req_wdata;
                            end else begin
                                state    <= ST_READ;
                                mem_read <= 1'b1;
                            end
                        end
                    end
                end
                ST_READ: begin
                    mem_read <= 1'b0;
                    if (r_store) begin
                        state          <= ST_WRITE;
                        mem_write      <= 1'b1;
                        mem_write_data <= merged_word;
                    end else begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= load_data;
                    end
                end
                ST_WRITE: begin
                    state          <= ST_RESP;
                    mem_write      <= 1'b0;
                    mem_write_data <= '0;
                    resp_valid     <= 1'b1;
                    resp_err       <= 1'b0;
                    resp_data      <= '0;
                end
                ST_RESP: begin
                    // Accepting a new request here would skip the IDLE cycle.
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        resp_data  <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
